// File: rtl/pipe_pkg.sv
// pipe_pkg: shared definitions for the integer-pipeline hazard controller.
//   - hz_state_e : hazard FSM states (RUN, LU_STALL, DC_STALL)
//   - STG_*      : bit index of each inter-stage register in en_reg/flush
//   - OP_*       : 6-bit opcodes seen in the decode stage
package pipe_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    DC_STALL = 2'd2
  } hz_state_e;

  localparam int STG_FETCH  = 0;
  localparam int STG_DECODE = 1;
  localparam int STG_ALU    = 2;
  localparam int STG_MEM    = 3;

  localparam logic [5:0] OP_ARITH  = 6'b000000;
  localparam logic [5:0] OP_CMP    = 6'b000001;
  localparam logic [5:0] OP_ADDI   = 6'b000010;
  localparam logic [5:0] OP_LOADB  = 6'b000011;
  localparam logic [5:0] OP_LOADW  = 6'b000100;
  localparam logic [5:0] OP_STOREB = 6'b000101;
  localparam logic [5:0] OP_STOREW = 6'b000110;
  localparam logic [5:0] OP_MVL    = 6'b000111;
  localparam logic [5:0] OP_MVH    = 6'b001000;
  localparam logic [5:0] OP_MVI    = 6'b001001;
  localparam logic [5:0] OP_BEQ    = 6'b001010;
  localparam logic [5:0] OP_BNE    = 6'b001011;
  localparam logic [5:0] OP_JAL    = 6'b001100;
  localparam logic [5:0] OP_JUMP   = 6'b001101;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: bundle between the integer pipeline and its hazard controller.
//   master : pipeline side - drives decode/ALU hazard info and cache stalls,
//            receives register enables, flushes, status and perf counters.
//   slave  : hazard controller side (pipe_hazard_ctrl).
interface pipe_hazard_ctrl_if #(
  parameter int STAGES = 4,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 32
);
  logic [5:0]        opcode_d;
  logic [REG_W-1:0]  rega_d;
  logic [REG_W-1:0]  regb_d;
  logic              ex_is_load;
  logic [REG_W-1:0]  ex_regd;
  logic              branch_taken_ex;
  logic              block_pipe_instr_cache;
  logic              block_pipe_data_cache;
  logic [STAGES-1:0] en_reg;
  logic [STAGES-1:0] flush;
  logic              injecting_nop;
  logic              lu_busy;
  logic [CNT_W-1:0]  cnt_dc;
  logic [CNT_W-1:0]  cnt_ic;
  logic [CNT_W-1:0]  cnt_lu;
  logic [CNT_W-1:0]  cnt_br;

  modport master (
    output opcode_d, rega_d, regb_d, ex_is_load, ex_regd, branch_taken_ex,
           block_pipe_instr_cache, block_pipe_data_cache,
    input  en_reg, flush, injecting_nop, lu_busy, cnt_dc, cnt_ic, cnt_lu, cnt_br
  );

  modport slave (
    input  opcode_d, rega_d, regb_d, ex_is_load, ex_regd, branch_taken_ex,
           block_pipe_instr_cache, block_pipe_data_cache,
    output en_reg, flush, injecting_nop, lu_busy, cnt_dc, cnt_ic, cnt_lu, cnt_br
  );
endinterface

// File: rtl/hazard_src_decode.sv
// hazard_src_decode: combinational source-register usage decode.
//   opcode_d_i : opcode in the decode stage
//   uses_a_o   : instruction reads regA
//   uses_b_o   : instruction reads regB
module hazard_src_decode
  import pipe_pkg::*;
(
  input  logic [5:0] opcode_d_i,
  output logic       uses_a_o,
  output logic       uses_b_o
);

  always_comb begin
    uses_a_o = 1'b1;
    uses_b_o = 1'b0;
    case (opcode_d_i)
      OP_ARITH, OP_CMP, OP_STOREB, OP_STOREW, OP_BEQ, OP_BNE: begin
        uses_a_o = 1'b1;
        uses_b_o = 1'b1;
      end
      OP_MVL, OP_MVH, OP_MVI: begin
        uses_a_o = 1'b0;
        uses_b_o = 1'b0;
      end
      OP_ADDI, OP_LOADB, OP_LOADW, OP_JAL, OP_JUMP: begin
        uses_a_o = 1'b1;
        uses_b_o = 1'b0;
      end
      default: begin
        uses_a_o = 1'b1;
        uses_b_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush controller for the integer pipeline.
// Produces per-stage register enables and flushes from cache stalls, taken
// branches and load-use hazards. A small FSM counts multi-cycle load-use
// bubbles and keeps an in-progress bubble sequence alive across data-cache
// freezes.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : pipe_hazard_ctrl_if.slave (hazard inputs, en_reg/flush,
//                injecting_nop, lu_busy, perf counters)
// Build option: define HAZARD_PERF_EN to build the saturating performance
// counters; otherwise cnt_* are tied to zero.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int STAGES     = 4,
  parameter int REG_W      = 5,
  parameter int LU_BUBBLES = 1,
  parameter int CNT_W      = 32
) (
  input  logic                clk,
  input  logic                reset,
  pipe_hazard_ctrl_if.slave   bus
);

  localparam logic [1:0] S_RUN = RUN;
  localparam logic [1:0] S_LU  = LU_STALL;
  localparam logic [1:0] S_DC  = DC_STALL;

  logic              uses_a, uses_b, hazard;
  logic [1:0]        state_q, state_d, eff_state;
  logic [2:0]        bub_q, bub_d;
  logic              ret_q, ret_d;       // 1 = return to LU_STALL
  logic [STAGES-1:0] en_d, flush_d;
  logic              inj_d;
  logic              dc_rule, br_rule, lu_rule;

  hazard_src_decode u_dec (
    .opcode_d_i (bus.opcode_d),
    .uses_a_o   (uses_a),
    .uses_b_o   (uses_b)
  );

  assign hazard = bus.ex_is_load && (bus.ex_regd != '0) &&
                  ((uses_a && (bus.rega_d == bus.ex_regd)) ||
                   (uses_b && (bus.regb_d == bus.ex_regd)));

  // Leaving DC_STALL, the lower-priority rules act as if in the saved state.
  assign eff_state = (state_q == S_DC) ? (ret_q ? S_LU : S_RUN) : state_q;

  always_comb begin
    en_d    = '1;
    flush_d = '0;
    inj_d   = 1'b0;
    state_d = eff_state;
    bub_d   = bub_q;
    ret_d   = ret_q;
    dc_rule = 1'b0;
    br_rule = 1'b0;
    lu_rule = 1'b0;
    // Outputs sit at their reset values for the whole time reset is high.
    if (!reset) begin
      if (bus.block_pipe_data_cache) begin
        dc_rule = 1'b1;
        en_d    = '0;
        state_d = S_DC;
        ret_d   = (eff_state == S_LU);
      end else if (bus.branch_taken_ex && (eff_state == S_RUN)) begin
        // en_reg[FETCH] stays 1 so the redirect is captured even on an I$ miss.
        br_rule             = 1'b1;
        flush_d[STG_FETCH]  = 1'b1;
        flush_d[STG_DECODE] = 1'b1;
      end else if ((hazard && (eff_state == S_RUN)) || (eff_state == S_LU)) begin
        lu_rule             = 1'b1;
        en_d[STG_FETCH]     = 1'b0;
        en_d[STG_DECODE]    = 1'b0;
        flush_d[STG_ALU]    = 1'b1;
        if (eff_state == S_RUN) begin
          if (LU_BUBBLES > 1) begin
            bub_d   = 3'(LU_BUBBLES - 1);
            state_d = S_LU;
          end
        end else begin
          bub_d   = bub_q - 3'd1;
          state_d = (bub_q == 3'd1) ? S_RUN : S_LU;
        end
      end else if (bus.block_pipe_instr_cache) begin
        en_d[STG_FETCH]     = 1'b0;
        flush_d[STG_DECODE] = 1'b1;
        inj_d               = 1'b1;
      end
    end
  end

  assign bus.en_reg        = en_d;
  assign bus.flush         = flush_d;
  assign bus.injecting_nop = inj_d;
  assign bus.lu_busy       = !reset && (state_q == S_LU);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_RUN;
      bub_q   <= 3'd0;
      ret_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bub_q   <= bub_d;
      ret_q   <= ret_d;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] cnt_dc_q, cnt_ic_q, cnt_lu_q, cnt_br_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_dc_q <= '0;
      cnt_ic_q <= '0;
      cnt_lu_q <= '0;
      cnt_br_q <= '0;
    end else begin
      if (dc_rule) cnt_dc_q <= sat_inc(cnt_dc_q);
      if (inj_d)   cnt_ic_q <= sat_inc(cnt_ic_q);
      if (lu_rule) cnt_lu_q <= sat_inc(cnt_lu_q);
      if (br_rule) cnt_br_q <= sat_inc(cnt_br_q);
    end
  end

  assign bus.cnt_dc = cnt_dc_q;
  assign bus.cnt_ic = cnt_ic_q;
  assign bus.cnt_lu = cnt_lu_q;
  assign bus.cnt_br = cnt_br_q;
`else
  assign bus.cnt_dc = '0;
  assign bus.cnt_ic = '0;
  assign bus.cnt_lu = '0;
  assign bus.cnt_br = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed-vector bench for pipe_hazard_ctrl with three
// instances (LU_BUBBLES = 1, 3, 4) sharing one stimulus set.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic [4:0] rega, regb, ex_regd;
  logic       ex_is_load, branch, icm, dcm;

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.STAGES(4), .REG_W(5), .CNT_W(32)) b1 ();
  pipe_hazard_ctrl_if #(.STAGES(4), .REG_W(5), .CNT_W(32)) b3 ();
  pipe_hazard_ctrl_if #(.STAGES(4), .REG_W(5), .CNT_W(32)) b4 ();

  assign b1.opcode_d = opcode;  assign b3.opcode_d = opcode;  assign b4.opcode_d = opcode;
  assign b1.rega_d = rega;      assign b3.rega_d = rega;      assign b4.rega_d = rega;
  assign b1.regb_d = regb;      assign b3.regb_d = regb;      assign b4.regb_d = regb;
  assign b1.ex_is_load = ex_is_load; assign b3.ex_is_load = ex_is_load; assign b4.ex_is_load = ex_is_load;
  assign b1.ex_regd = ex_regd;  assign b3.ex_regd = ex_regd;  assign b4.ex_regd = ex_regd;
  assign b1.branch_taken_ex = branch; assign b3.branch_taken_ex = branch; assign b4.branch_taken_ex = branch;
  assign b1.block_pipe_instr_cache = icm; assign b3.block_pipe_instr_cache = icm; assign b4.block_pipe_instr_cache = icm;
  assign b1.block_pipe_data_cache = dcm;  assign b3.block_pipe_data_cache = dcm;  assign b4.block_pipe_data_cache = dcm;

  pipe_hazard_ctrl #(.STAGES(4), .REG_W(5), .LU_BUBBLES(1), .CNT_W(32)) u1 (.clk(clk), .reset(reset), .bus(b1.slave));
  pipe_hazard_ctrl #(.STAGES(4), .REG_W(5), .LU_BUBBLES(3), .CNT_W(32)) u3 (.clk(clk), .reset(reset), .bus(b3.slave));
  pipe_hazard_ctrl #(.STAGES(4), .REG_W(5), .LU_BUBBLES(4), .CNT_W(32)) u4 (.clk(clk), .reset(reset), .bus(b4.slave));

`ifdef HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  int nvec = 0;
  int nmis = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // A taken branch can never resolve while a load-use bubble sits in ALU.
  always @(negedge clk) begin
    if (!reset)
      assert (!(branch && (b3.lu_busy || b4.lu_busy)))
        else $error("branch_taken_ex during LU_STALL");
  end

  task automatic idle();
    opcode = 6'b000000; rega = '0; regb = '0; ex_regd = '0;
    ex_is_load = 1'b0; branch = 1'b0; icm = 1'b0; dcm = 1'b0;
  endtask

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    nxt();
    reset = 1'b0;
  endtask

  task automatic load_use(input logic [4:0] r);
    opcode = 6'b000000; rega = 5'd3; regb = r; ex_is_load = 1'b1; ex_regd = r;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset values hold regardless of inputs while reset is high.
    reset = 1'b1;
    idle();
    load_use(5'd7);
    dcm = 1'b1; icm = 1'b1;
    #2;
    check("rst en", 32'(b1.en_reg), 32'hF);
    check("rst flush", 32'(b1.flush), 32'h0);
    check("rst inj", 32'(b1.injecting_nop), 32'h0);
    check("rst busy", 32'(b4.lu_busy), 32'h0);
    check("rst cnt_dc", b1.cnt_dc, 32'h0);
    nxt();

    // Single-bubble load-use on regB.
    do_reset();
    load_use(5'd7);
    @(negedge clk);
    check("lu1 en", 32'(b1.en_reg), 32'hC);
    check("lu1 flush", 32'(b1.flush), 32'h4);
    check("lu1 inj", 32'(b1.injecting_nop), 32'h0);
    nxt();
    ex_is_load = 1'b0;
    @(negedge clk);
    check("lu1 after en", 32'(b1.en_reg), 32'hF);
    check("lu1 after flush", 32'(b1.flush), 32'h0);

    // Three bubbles with a 2-cycle D$ stall during bubble 2.
    nxt();
    do_reset();
    load_use(5'd7);
    @(negedge clk);
    check("lu3 b1 en", 32'(b3.en_reg), 32'hC);
    check("lu3 b1 flush", 32'(b3.flush), 32'h4);
    nxt();
    ex_is_load = 1'b0; dcm = 1'b1;
    @(negedge clk);
    check("lu3 dc1 en", 32'(b3.en_reg), 32'h0);
    check("lu3 dc1 busy", 32'(b3.lu_busy), 32'h1);
    nxt();
    @(negedge clk);
    check("lu3 dc2 en", 32'(b3.en_reg), 32'h0);
    check("lu3 dc2 flush", 32'(b3.flush), 32'h0);
    nxt();
    dcm = 1'b0;
    @(negedge clk);
    check("lu3 b2 en", 32'(b3.en_reg), 32'hC);
    check("lu3 b2 flush", 32'(b3.flush), 32'h4);
    nxt();
    @(negedge clk);
    check("lu3 b3 en", 32'(b3.en_reg), 32'hC);
    check("lu3 b3 busy", 32'(b3.lu_busy), 32'h1);
    nxt();
    @(negedge clk);
    check("lu3 done en", 32'(b3.en_reg), 32'hF);
    check("lu3 done busy", 32'(b3.lu_busy), 32'h0);
    check("lu3 cnt_lu", b3.cnt_lu, PERF ? 32'd3 : 32'd0);
    check("lu3 cnt_dc", b3.cnt_dc, PERF ? 32'd2 : 32'd0);

    // No-stall cases and source decode.
    nxt();
    do_reset();
    opcode = 6'b000000; rega = 5'd0; regb = 5'd0; ex_is_load = 1'b1; ex_regd = 5'd0;
    @(negedge clk);
    check("r0 en", 32'(b1.en_reg), 32'hF);
    nxt();
    opcode = 6'b001001; rega = 5'd5; ex_regd = 5'd5;
    @(negedge clk);
    check("mvi en", 32'(b1.en_reg), 32'hF);
    nxt();
    opcode = 6'b000010; rega = 5'd1; regb = 5'd5;
    @(negedge clk);
    check("addi regb en", 32'(b1.en_reg), 32'hF);
    nxt();
    rega = 5'd5;
    @(negedge clk);
    check("addi rega en", 32'(b1.en_reg), 32'hC);
    nxt();
    opcode = 6'b001011; rega = 5'd1; regb = 5'd5;
    @(negedge clk);
    check("bne regb en", 32'(b1.en_reg), 32'hC);
    nxt();
    ex_is_load = 1'b0;
    @(negedge clk);
    check("noload en", 32'(b1.en_reg), 32'hF);

    // Branch priority over I$ stall and over a load-use hazard.
    nxt();
    do_reset();
    branch = 1'b1; icm = 1'b1;
    @(negedge clk);
    check("br+ic flush", 32'(b1.flush), 32'h3);
    check("br+ic en", 32'(b1.en_reg), 32'hF);
    check("br+ic inj", 32'(b1.injecting_nop), 32'h0);
    nxt();
    icm = 1'b0; load_use(5'd9);
    @(negedge clk);
    check("br+lu flush", 32'(b1.flush), 32'h3);
    check("br+lu en", 32'(b1.en_reg), 32'hF);
    nxt();
    branch = 1'b0; ex_is_load = 1'b0;
    @(negedge clk);
    check("br cnt_br", b1.cnt_br, PERF ? 32'd2 : 32'd0);

    // Both cache stalls for 5 cycles, then I$ only.
    nxt();
    do_reset();
    dcm = 1'b1; icm = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("dc+ic en", 32'(b1.en_reg), 32'h0);
      check("dc+ic inj", 32'(b1.injecting_nop), 32'h0);
      nxt();
    end
    dcm = 1'b0;
    @(negedge clk);
    check("ic en", 32'(b1.en_reg), 32'hE);
    check("ic flush", 32'(b1.flush), 32'h2);
    check("ic inj", 32'(b1.injecting_nop), 32'h1);
    check("ic cnt_dc", b1.cnt_dc, PERF ? 32'd5 : 32'd0);
    nxt();
    icm = 1'b0;
    @(negedge clk);
    check("ic cnt_ic", b1.cnt_ic, PERF ? 32'd1 : 32'd0);
    check("ic clear en", 32'(b1.en_reg), 32'hF);

    // Reset mid LU_STALL (LU_BUBBLES=4, counter=2).
    nxt();
    do_reset();
    load_use(5'd7);
    @(negedge clk);
    check("lu4 b1 en", 32'(b4.en_reg), 32'hC);
    nxt();
    ex_is_load = 1'b0;
    @(negedge clk);
    check("lu4 b2 busy", 32'(b4.lu_busy), 32'h1);
    nxt();
    #1;
    reset = 1'b1;
    #1;
    check("lu4 rst en", 32'(b4.en_reg), 32'hF);
    check("lu4 rst flush", 32'(b4.flush), 32'h0);
    check("lu4 rst busy", 32'(b4.lu_busy), 32'h0);
    nxt();
    reset = 1'b0;
    @(negedge clk);
    check("lu4 post en", 32'(b4.en_reg), 32'hF);
    check("lu4 post busy", 32'(b4.lu_busy), 32'h0);
    nxt();
    @(negedge clk);
    check("lu4 post2 en", 32'(b4.en_reg), 32'hF);
    check("lu4 post2 busy", 32'(b4.lu_busy), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Parametrised pipeline hazard and stall controller. It generates per-stage pipeline-register enables and flushes from the instruction- and data-cache stall requests, taken-branch resolution, and load-use detection. Multi-cycle load-use bubbles are counted by a small FSM, and an in-progress bubble sequence is preserved across data-cache freezes. It sits beside the decode stage and drives every inter-stage register of the integer pipeline.

## Interface
- STAGES, 4, number of pipeline registers (index 0=FETCH, 1=DECODE, 2=ALU, 3=MEM…); minimum 3
- REG_W, 5, register-address width
- LU_BUBBLES, 1, bubbles inserted per load-use hazard; range 1..7
- CNT_W, 32, performance-counter width

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- opcode_d  in  6  opcode of instruction in decode
- rega_d, regb_d  in  REG_W  source registers in decode
- ex_is_load  in  1  instruction in ALU stage is loadb/loadw
- ex_regd  in  REG_W  destination of that instruction
- branch_taken_ex  in  1  taken branch/jump resolved in ALU stage
- block_pipe_instr_cache  in  1  instruction-cache miss
- block_pipe_data_cache  in  1  data-cache miss
- en_reg  out  STAGES  pipeline-register enables
- flush  out  STAGES  load a NOP into the register (valid only when en_reg bit=1)
- injecting_nop  out  1  NOP injected into DECODE this cycle
- lu_busy  out  1  FSM is in LU_STALL
- cnt_dc, cnt_ic, cnt_lu, cnt_br  out  CNT_W  performance counters

## Operation
- Source use is decoded from opcode_d:
  - 000000, 000001, 000101, 000110, 001010, 001011 use regA and regB.
  - 000111, 001000, 001001 use no sources.
  - All other opcodes use regA only.
- Hazard: ex_is_load & ex_regd≠0 & ((uses_a & rega_d==ex_regd) | (uses_b & regb_d==ex_regd)).
- FSM states: RUN, LU_STALL, DC_STALL. A 3-bit bubble counter and a 1-bit return-state register are kept.
- Actions are evaluated in strict priority order; default is en_reg all 1, flush all 0.
  1. block_pipe_data_cache: en_reg all 0. Go to DC_STALL and save the return state (RUN or LU_STALL). The bubble counter is held.
  2. branch_taken_ex (RUN only): flush[0]=flush[1]=1. State stays RUN.
  3. Hazard in RUN, or state LU_STALL:
     - en_reg[0]=en_reg[1]=0 and flush[2]=1.
     - From RUN: if LU_BUBBLES>1, counter←LU_BUBBLES−1 and go to LU_STALL.
     - In LU_STALL: decrement the counter; go to RUN when it was 1.
  4. block_pipe_instr_cache: en_reg[0]=0, flush[1]=1, injecting_nop=1.
- DC_STALL: hold while block_pipe_data_cache=1. On deassert, apply this same cycle's lower-priority rules as if in the saved return state, and transition accordingly.
- branch_taken_ex in LU_STALL cannot occur (ALU holds a bubble). The block ignores it there; the bench flags it with an assertion.
- Instruction-cache and data-cache stalls in the same cycle: the data-cache rule alone applies and injecting_nop=0.
- Branch and instruction-cache stall in the same cycle: the branch flush applies, and en_reg[0]=1 so the redirect is captured.

## Timing
- en_reg, flush and injecting_nop are combinational from the inputs plus registered state. There are zero cycles of latency from any input.
- The state, counter and return-state registers update on posedge clk.
- Reset, asynchronous:
  - state=RUN, counter=0, return=RUN, all counters 0.
  - While reset=1: en_reg all 1, flush all 0, injecting_nop=0, lu_busy=0.
- Reset asserted mid-LU_STALL or mid-DC_STALL aborts immediately. The first cycle after release behaves as RUN.
- A load-use hazard costs exactly LU_BUBBLES cycles plus any data-cache stall cycles.

## Configuration
- HAZARD_PERF_EN defined, saturating counters (each stops at all-ones):
  - cnt_dc increments each cycle data-cache rule applies.
  - cnt_ic increments each cycle injecting_nop=1.
  - cnt_lu increments each bubble cycle.
  - cnt_br increments each branch flush.
- HAZARD_PERF_EN undefined: counters are not built and the four ports are tied to 0.

## Structure
- Shared package pipe_pkg holds:
  - The state enum (RUN, LU_STALL, DC_STALL).
  - Stage indices STG_FETCH..STG_MEM.
  - The 6-bit opcode localparams (OP_ARITH, OP_CMP, OP_ADDI, OP_LOADB, OP_LOADW, OP_STOREB, OP_STOREW, OP_MVL, OP_MVH, OP_MVI, OP_JAL, OP_JUMP, …).
- One combinational sub-module, hazard_src_decode: opcode_d → uses_a, uses_b.

## Test plan
- Arithmetic (000000) in decode with regb_d=7 while ex_is_load=1, ex_regd=7 → en_reg=4'b1100, flush=4'b0100 for one cycle, then en_reg=4'b1111.
- LU_BUBBLES=3, same hazard, data-cache stall in the 2nd bubble for 2 cycles → bubble cycles 1,·,·,2,3. en_reg=0 during stall. 3 bubbles total.
- ex_regd=0 matching rega_d=0 → no stall. Also mvi (001001) with rega_d==ex_regd → no stall.
- branch_taken_ex=1 with block_pipe_instr_cache=1 → flush=4'b0011, en_reg=4'b1111, injecting_nop=0.
- Both cache stalls for 5 cycles, then instruction-cache stall only → 5 cycles en_reg=0, then en_reg=4'b1110, injecting_nop=1. cnt_dc=5 with HAZARD_PERF_EN, and 0 without.
- reset asserted in LU_STALL (LU_BUBBLES=4, counter=2) → outputs immediately at reset values. After release, a cycle with no hazard gives en_reg=4'b1111 and lu_busy=0.
